// File: rtl/parser_pkg.sv
// Shared parser types: type-lookup rule layout, config command codes, config FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package parser_pkg;

  // Number of type-lookup rule slots in the parser.
  localparam int TYPE_RULE_NUM = 4;

  // One type-lookup rule. Bit 0 is the LSB of the last field.
  typedef struct packed {
    logic        typeRule_valid;
    logic [15:0] typeRule_ethType;
    logic [15:0] typeRule_ethTypeMask;
    logic [7:0]  typeRule_nextHdr;
    logic [7:0]  typeRule_keyOffset;
  } type_rule_t;

  localparam int TYPE_RULE_W = $bits(type_rule_t);
  localparam int CFG_DW_DEF  = 32;

  // Number of config words needed to hold one rule; the last word is truncated.
  function automatic int rule_words(input int dw);
    return (TYPE_RULE_W + dw - 1) / dw;
  endfunction

  localparam int RULE_WORDS = rule_words(CFG_DW_DEF);

  // Word-index field values that act as commands instead of staging writes.
  localparam logic [7:0] CMD_COMMIT = 8'hFF;
  localparam logic [7:0] CMD_CLEAR  = 8'hFE;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_IDLE = 2'd1,
    ST_WRITE     = 2'd2,
    ST_CLEAR     = 2'd3
  } cfg_state_t;

endpackage

// File: rtl/type_rule_cfg.sv
// Config agent: stages a type rule word by word, then commits it (or clears all rules) into the rule table.
// Latency: commit wren 1 cycle after the handshake when lookup is idle; clear-all takes RULE_NUM write cycles.
// Backpressure: o_cfg_ready only in IDLE; table writes wait for i_lookup_idle so no packet sees a half-written rule.
module type_rule_cfg
  import parser_pkg::*;
#(
  parameter int RULE_NUM = TYPE_RULE_NUM,
  parameter int CFG_DW   = 32
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_cfg_valid,
  output logic                o_cfg_ready,
  input  logic [15:0]         i_cfg_addr,
  input  logic [CFG_DW-1:0]   i_cfg_wdata,
  output logic                o_cfg_err,
  input  logic                i_lookup_idle,
  output logic [RULE_NUM-1:0] o_rule_wren,
  output type_rule_t          o_type_rule,
  output logic                o_busy
);

  localparam int RW = rule_words(CFG_DW);
  localparam int IW = (RULE_NUM > 1) ? $clog2(RULE_NUM) : 1;

  cfg_state_t            r_state;
  logic [TYPE_RULE_W-1:0] r_stage;
  logic [IW-1:0]         r_idx;
  logic [IW-1:0]         r_cnt;
  logic                  r_is_clear;
  logic                  r_ready;
  logic                  r_busy;
  logic                  r_err;
  logic [RULE_NUM-1:0]   r_wren;
  type_rule_t            r_rule;

  logic [7:0] w_rule_idx;
  logic [7:0] w_word_idx;
  logic       w_hs;
  type_rule_t w_rule;

  assign w_rule_idx = i_cfg_addr[15:8];
  assign w_word_idx = i_cfg_addr[7:0];
  assign w_hs       = i_cfg_valid & r_ready;
  assign w_rule     = type_rule_t'(r_stage);

  function automatic logic [RULE_NUM-1:0] onehot(input logic [IW-1:0] idx);
    return RULE_NUM'(1) << idx;
  endfunction

  // Config FSM: staging writes, command decode, and the registered table-write outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_stage    <= '0;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_is_clear <= 1'b0;
      r_ready    <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
      r_wren     <= '0;
      r_rule     <= '0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_wren  <= '0;
          r_rule  <= '0;
          if (w_hs) begin
            if (int'(w_word_idx) < RW) begin
              // Word k covers rule bits [k*CFG_DW +: CFG_DW]; bits past the rule width are dropped.
              for (int b = 0; b < TYPE_RULE_W; b++) begin
                if (int'(w_word_idx) == b / CFG_DW) begin
                  r_stage[b] <= i_cfg_wdata[b % CFG_DW];
                end
              end
            end else if (w_word_idx == CMD_COMMIT && int'(w_rule_idx) < RULE_NUM) begin
              r_idx      <= w_rule_idx[IW-1:0];
              r_is_clear <= 1'b0;
              r_state    <= ST_WAIT_IDLE;
              r_ready    <= 1'b0;
              r_busy     <= 1'b1;
            end else if (w_word_idx == CMD_CLEAR) begin
              r_cnt      <= '0;
              r_is_clear <= 1'b1;
              r_state    <= ST_WAIT_IDLE;
              r_ready    <= 1'b0;
              r_busy     <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        ST_WAIT_IDLE: begin
          if (i_lookup_idle) begin
            if (r_is_clear) begin
              r_state <= ST_CLEAR;
              r_wren  <= onehot(r_cnt);
              r_rule  <= '0;
            end else begin
              r_state <= ST_WRITE;
              r_wren  <= onehot(r_idx);
              r_rule  <= w_rule;
            end
          end
        end
        ST_WRITE: begin
          r_state <= ST_IDLE;
          r_wren  <= '0;
          r_rule  <= '0;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
        ST_CLEAR: begin
          if (r_cnt == IW'(RULE_NUM - 1)) begin
            r_state <= ST_IDLE;
            r_wren  <= '0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_cnt  <= r_cnt + IW'(1);
            r_wren <= onehot(r_cnt + IW'(1));
          end
          r_rule <= '0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_wren  <= '0;
          r_rule  <= '0;
        end
      endcase
    end
  end

  assign o_cfg_ready = r_ready;
  assign o_cfg_err   = r_err;
  assign o_busy      = r_busy;
  assign o_rule_wren = r_wren;
  assign o_type_rule = r_rule;

endmodule

// File: tb/tb_type_rule_cfg.sv
module tb_type_rule_cfg;
  import parser_pkg::*;

  localparam int RN = 4;
  localparam int DW = 32;

  logic          clk;
  logic          rst_n;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [15:0]   cfg_addr;
  logic [DW-1:0] cfg_wdata;
  logic          cfg_err;
  logic          lookup_idle;
  logic [RN-1:0] rule_wren;
  type_rule_t    type_rule;
  logic          busy;

  int n_tests;
  int n_fail;

  logic [31:0] w0;
  logic [31:0] w1;
  logic [TYPE_RULE_W-1:0] flat;
  type_rule_t  exp_rule;
  type_rule_t  first_rule;

  type_rule_cfg #(.RULE_NUM(RN), .CFG_DW(DW)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_cfg_valid  (cfg_valid),
    .o_cfg_ready  (cfg_ready),
    .i_cfg_addr   (cfg_addr),
    .i_cfg_wdata  (cfg_wdata),
    .o_cfg_err    (cfg_err),
    .i_lookup_idle(lookup_idle),
    .o_rule_wren  (rule_wren),
    .o_type_rule  (type_rule),
    .o_busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs and samples sit 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One config handshake (ready is high whenever this is called).
  task automatic cfg(input logic [15:0] addr, input logic [31:0] data);
    cfg_valid = 1'b1;
    cfg_addr  = addr;
    cfg_wdata = data;
    step();
    cfg_valid = 1'b0;
    cfg_addr  = '0;
    cfg_wdata = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_tests++;
    if (rule_wren !== 4'b0 || type_rule !== '0 || cfg_err !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: wren=%b rule=%h err=%b busy=%b ready=%b, want all 0",
               rule_wren, type_rule, cfg_err, busy, cfg_ready);
    end
    step();
    rst_n = 1'b1;
    step();
    n_tests++;
    if (cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready_rise: ready=%b, want 1", cfg_ready);
    end
    // Staging is zero after reset: committing rule 3 writes an all-zero rule.
    lookup_idle = 1'b1;
    cfg(16'h03FF, 32'h0);
    step();
    n_tests++;
    if (rule_wren !== 4'b1000 || type_rule !== '0) begin
      n_fail++;
      $display("FAIL reset_staging_zero: wren=%b rule=%h, want 1000 / 0", rule_wren, type_rule);
    end
    step();
  endtask

  task automatic test_commit();
    w0 = 32'hA5A5_1234;
    w1 = 32'hFFF1_BEEF;
    flat = {w1[TYPE_RULE_W-33:0], w0};
    exp_rule = type_rule_t'(flat);
    lookup_idle = 1'b1;
    cfg(16'h0000, w0);
    cfg(16'h0701, w1);
    n_tests++;
    if (cfg_ready !== 1'b1 || rule_wren !== 4'b0) begin
      n_fail++;
      $display("FAIL stage_stays_idle: ready=%b wren=%b, want 1 / 0000", cfg_ready, rule_wren);
    end
    cfg(16'h02FF, 32'h0);
    n_tests++;
    if (cfg_ready !== 1'b0 || busy !== 1'b1 || rule_wren !== 4'b0) begin
      n_fail++;
      $display("FAIL commit_wait_cycle: ready=%b busy=%b wren=%b, want 0 1 0000", cfg_ready, busy, rule_wren);
    end
    step();
    n_tests++;
    if (rule_wren !== 4'b0100 || type_rule !== exp_rule || cfg_ready !== 1'b0 || type_rule.typeRule_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL commit_write: wren=%b rule=%h ready=%b, want 0100 %h 0", rule_wren, type_rule, cfg_ready, exp_rule);
    end
    step();
    n_tests++;
    if (rule_wren !== 4'b0 || type_rule !== '0 || cfg_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL commit_done: wren=%b rule=%h ready=%b busy=%b, want 0 0 1 0", rule_wren, type_rule, cfg_ready, busy);
    end
  endtask

  task automatic test_wait_idle();
    int bad;
    bad = 0;
    lookup_idle = 1'b0;
    cfg(16'h01FF, 32'h0);
    for (int i = 0; i < 10; i++) begin
      if (rule_wren !== 4'b0 || busy !== 1'b1 || cfg_ready !== 1'b0) bad++;
      step();
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL wait_idle_hold: %0d bad cycles, want 0", bad);
    end
    lookup_idle = 1'b1;
    step();
    n_tests++;
    if (rule_wren !== 4'b0010 || type_rule !== exp_rule) begin
      n_fail++;
      $display("FAIL wait_idle_release: wren=%b rule=%h, want 0010 %h", rule_wren, type_rule, exp_rule);
    end
    step();
  endtask

  task automatic test_clear();
    logic [RN-1:0] exp_w;
    lookup_idle = 1'b1;
    cfg(16'h00FE, 32'h0);
    n_tests++;
    if (busy !== 1'b1 || rule_wren !== 4'b0) begin
      n_fail++;
      $display("FAIL clear_wait: busy=%b wren=%b, want 1 0000", busy, rule_wren);
    end
    exp_w = 4'b0001;
    for (int i = 0; i < RN; i++) begin
      step();
      n_tests++;
      if (rule_wren !== exp_w || type_rule !== '0 || cfg_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL clear_slot%0d: wren=%b rule=%h ready=%b, want %b 0 0", i, rule_wren, type_rule, cfg_ready, exp_w);
      end
      exp_w = exp_w << 1;
    end
    step();
    n_tests++;
    if (rule_wren !== 4'b0 || cfg_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_done: wren=%b ready=%b busy=%b, want 0 1 0", rule_wren, cfg_ready, busy);
    end
  endtask

  task automatic test_illegal();
    lookup_idle = 1'b1;
    cfg(16'h04FF, 32'h0);
    n_tests++;
    if (cfg_err !== 1'b1 || cfg_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL err_bad_rule: err=%b ready=%b busy=%b, want 1 1 0", cfg_err, cfg_ready, busy);
    end
    step();
    n_tests++;
    if (cfg_err !== 1'b0 || rule_wren !== 4'b0) begin
      n_fail++;
      $display("FAIL err_one_cycle: err=%b wren=%b, want 0 0000", cfg_err, rule_wren);
    end
    cfg(16'h0080, 32'hDEAD_BEEF);
    n_tests++;
    if (cfg_err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_word80: err=%b, want 1", cfg_err);
    end
    cfg(16'h0002, 32'h1234_5678);
    n_tests++;
    if (cfg_err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_word_rulewords: err=%b, want 1", cfg_err);
    end
    step();
    // Staging must still hold the earlier rule.
    cfg(16'h03FF, 32'h0);
    step();
    n_tests++;
    if (rule_wren !== 4'b1000 || type_rule !== exp_rule) begin
      n_fail++;
      $display("FAIL err_staging_kept: wren=%b rule=%h, want 1000 %h", rule_wren, type_rule, exp_rule);
    end
    step();
  endtask

  task automatic test_back_to_back();
    lookup_idle = 1'b1;
    cfg(16'h00FF, 32'h0);
    step();
    first_rule = type_rule;
    n_tests++;
    if (rule_wren !== 4'b0001 || first_rule !== exp_rule) begin
      n_fail++;
      $display("FAIL repeat_first: wren=%b rule=%h, want 0001 %h", rule_wren, first_rule, exp_rule);
    end
    step();
    cfg(16'h00FF, 32'h0);
    step();
    n_tests++;
    if (rule_wren !== 4'b0001 || type_rule !== first_rule) begin
      n_fail++;
      $display("FAIL repeat_second: wren=%b rule=%h, want 0001 %h", rule_wren, type_rule, first_rule);
    end
    step();
  endtask

  task automatic test_reset_mid_clear();
    int bad;
    bad = 0;
    lookup_idle = 1'b1;
    cfg(16'h00FE, 32'h0);
    step();
    step();
    n_tests++;
    if (rule_wren !== 4'b0010) begin
      n_fail++;
      $display("FAIL midclr_pre: wren=%b, want 0010", rule_wren);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (rule_wren !== 4'b0 || type_rule !== '0 || busy !== 1'b0 || cfg_ready !== 1'b0 || cfg_err !== 1'b0) begin
      n_fail++;
      $display("FAIL midclr_async: wren=%b rule=%h busy=%b ready=%b err=%b, want all 0",
               rule_wren, type_rule, busy, cfg_ready, cfg_err);
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (rule_wren !== 4'b0 || busy !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0 || cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midclr_after: %0d bad cycles ready=%b, want 0 / 1", bad, cfg_ready);
    end
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    cfg_valid   = 1'b0;
    cfg_addr    = '0;
    cfg_wdata   = '0;
    lookup_idle = 1'b0;
    test_reset();
    test_commit();
    test_wait_idle();
    test_clear();
    test_illegal();
    test_back_to_back();
    test_reset_mid_clear();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/type_rule_cfg.md
TYPE_RULE_CFG -- requirements
Module: type_rule_cfg

Interface
REQ-001 SHALL have parameter RULE_NUM, default from parser_pkg, meaning the number of type-lookup rule slots driven.
REQ-002 SHALL have parameter CFG_DW, default 32, meaning the config data width.
REQ-003 SHALL have port i_clk, input, 1, the single clock.
REQ-004 SHALL have port i_rst_n, input, 1, an asynchronous active-low reset.
REQ-005 SHALL have port i_cfg_valid, input, 1, config request valid.
REQ-006 SHALL have port o_cfg_ready, output, 1, config request accepted when high with i_cfg_valid.
REQ-007 SHALL have port i_cfg_addr, input, 16, where [15:8] is the rule index and [7:0] is the word index/command.
REQ-008 SHALL have port i_cfg_wdata, input, CFG_DW, the staging word data.
REQ-009 SHALL have port o_cfg_err, output, 1, a one-cycle pulse on an illegal request.
REQ-010 SHALL have port i_lookup_idle, input, 1, meaning no packet is in flight in the lookup stage.
REQ-011 SHALL have port o_rule_wren, output, RULE_NUM, a one-hot rule write enable.
REQ-012 SHALL have port o_type_rule, output, type_rule_t, the rule written by o_rule_wren.
REQ-013 SHALL have port o_busy, output, 1, high in every state except IDLE.

Function
REQ-014 SHALL hold a staging buffer of RULE_WORDS = ceil($bits(type_rule_t)/CFG_DW) words; word k maps to type_rule_t bits [k*CFG_DW +: CFG_DW], and the last word is truncated.
REQ-015 SHALL use the states IDLE, WAIT_IDLE, WRITE and CLEAR.
REQ-016 SHALL drive o_cfg_ready = 1 only in IDLE; a handshake is i_cfg_valid & o_cfg_ready.
REQ-017 SHALL handle a handshake with word index < RULE_WORDS as follows:
- write i_cfg_wdata into staging word[index] on that edge;
- ignore the rule index;
- remain in IDLE.
REQ-018 SHALL treat word index 0xFF as commit: if rule index < RULE_NUM, latch the index and go to WAIT_IDLE.
REQ-019 SHALL treat word index 0xFE as clear-all: reset the rule counter to 0 and go to WAIT_IDLE.
REQ-020 SHALL treat as illegal any handshake with word index in [RULE_WORDS, 0xFD], or a commit with rule index >= RULE_NUM:
- pulse o_cfg_err in the cycle after the handshake;
- make no staging change;
- remain in IDLE.
REQ-021 SHALL advance from WAIT_IDLE when i_lookup_idle = 1: to WRITE for a commit, to CLEAR for a clear-all; it waits indefinitely otherwise.
REQ-022 SHALL, in WRITE (exactly one cycle):
- drive o_rule_wren = 1 << latched index;
- drive o_type_rule = staging;
- go to IDLE on the next edge.
REQ-023 SHALL, in CLEAR:
- drive o_rule_wren = 1 << counter and o_type_rule = '0 for RULE_NUM consecutive cycles, counter 0..RULE_NUM-1;
- return to IDLE after the cycle with counter = RULE_NUM-1.
REQ-024 SHALL stay in CLEAR and WRITE regardless of i_lookup_idle once entered.
REQ-025 SHALL drive o_rule_wren = 0 and o_type_rule = '0 in IDLE and WAIT_IDLE.
REQ-026 SHALL preserve the staging buffer across commit and clear-all, so repeated commits rewrite identical rules.
REQ-027 SHALL give commit latency = 1 cycle after the handshake if i_lookup_idle is already high (WAIT_IDLE one cycle, then WRITE).
REQ-028 SHALL register all outputs; it has no combinational path from inputs to outputs.

Reset
REQ-029 SHALL, while i_rst_n = 0, force asynchronously:
- state = IDLE;
- staging = 0 and counter = 0;
- o_rule_wren = 0, o_type_rule = '0, o_cfg_err = 0, o_busy = 0;
- o_cfg_ready = 0.
REQ-030 SHALL raise o_cfg_ready on the first clock edge after reset release.
REQ-031 SHALL abandon an in-progress commit or clear on reset mid-operation; no further wren pulses follow.

Structure
REQ-032 SHALL place RULE_WORDS, the CMD_COMMIT (0xFF) and CMD_CLEAR (0xFE) constants, and the state enum in parser_pkg; type_rule_t stays there.
REQ-033 SHALL be a single module with no sub-module; the staging buffer is a flop array.

Verification
REQ-034 Scenario: write all RULE_WORDS words for a rule with typeRule_valid = 1, then commit rule 2 with i_lookup_idle = 1 -> o_rule_wren = 0b0100 for exactly one cycle, o_type_rule equals the assembled words, o_cfg_ready low for 2 cycles.
REQ-035 Scenario: commit rule 1 with i_lookup_idle = 0 for 10 cycles -> no wren, o_busy = 1, o_cfg_ready = 0 throughout; the wren pulse comes 1 cycle after idle rises.
REQ-036 Scenario: clear-all with RULE_NUM = 4 -> o_rule_wren = 1, 2, 4, 8 on 4 consecutive cycles, o_type_rule = 0, then IDLE.
REQ-037 Scenario: commit rule index = RULE_NUM, and word index 0x80 -> o_cfg_err pulses once each; no wren; staging unchanged.
REQ-038 Scenario: assert reset during CLEAR at counter = 1 -> outputs zero immediately; after release, no remaining wren pulses and o_cfg_ready = 1.
REQ-039 Scenario: commit rule 0 twice without rewriting staging -> two identical o_type_rule values on wren pulses.
